// File: rtl/segre_if_stage.sv
// -----------------------------------------------------------------------------
// segre_if_stage : instruction fetch stage feeding decode.
//
// Owns the fetch PC and issues one request at a time to instruction memory
// over a req/gnt/rvalid handshake. Each response is registered onto
// instr_o/pc_o. If decode is stalled when a response arrives, the response
// is parked in a one-entry buffer. Taken branch/jump redirects from execute
// flush the stage and retarget the fetch PC. A response that is already in
// flight when a redirect occurs is discarded when it arrives.
//
// Ports
//   clk_i, rsn_i        clock (rising edge), synchronous active-high reset
//   hazard_i            decode stall: hold instr_o/pc_o/instr_valid_o
//   tkbr_i, new_pc_i    taken redirect and its target
//   imem_req_o/addr_o   fetch request and word-aligned address
//   imem_gnt_i          request accepted
//   imem_rvalid_i/rdata response valid and fetched instruction
//   instr_o, pc_o       instruction/PC pair presented to decode
//   instr_valid_o       instr_o holds a real fetched instruction
//
// Optional build macro SEGRE_IF_PERF_CNT_EN adds two counters:
//   fetch_cnt_o         instructions delivered to decode
//   stall_cnt_o         cycles where a valid instruction was held by hazard_i
// -----------------------------------------------------------------------------
module segre_if_stage #(
  parameter int                   WORD_SIZE = 32,
  parameter logic [WORD_SIZE-1:0] BOOT_ADDR = 32'h0000_0000,
  parameter logic [WORD_SIZE-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 hazard_i,
  input  logic                 tkbr_i,
  input  logic [WORD_SIZE-1:0] new_pc_i,
  output logic                 imem_req_o,
  output logic [WORD_SIZE-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [WORD_SIZE-1:0] imem_rdata_i,
  output logic [WORD_SIZE-1:0] instr_o,
  output logic [WORD_SIZE-1:0] pc_o,
  output logic                 instr_valid_o
`ifdef SEGRE_IF_PERF_CNT_EN
  ,
  output logic [31:0]          fetch_cnt_o,
  output logic [31:0]          stall_cnt_o
`endif
);

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    HOLD       = 2'd2,
    FLUSH_WAIT = 2'd3
  } state_t;

  // Clearing the low two bits with a mask keeps every input bit in use.
  localparam logic [WORD_SIZE-1:0] ALIGN_MASK = ~WORD_SIZE'(3);

  state_t               state_reg, state_next;
  logic [WORD_SIZE-1:0] fetch_pc_reg, fetch_pc_next;
  logic [WORD_SIZE-1:0] req_pc_reg, req_pc_next;     // PC of the outstanding request
  logic [WORD_SIZE-1:0] instr_reg, instr_next;
  logic [WORD_SIZE-1:0] pc_reg, pc_next;
  logic                 valid_reg, valid_next;
  logic [WORD_SIZE-1:0] buf_instr_reg, buf_instr_next;
  logic [WORD_SIZE-1:0] buf_pc_reg, buf_pc_next;
  logic                 load_new;                    // fresh instruction delivered this edge
  logic [WORD_SIZE-1:0] fetch_addr;

  assign fetch_addr    = fetch_pc_reg & ALIGN_MASK;
  // Request is suppressed while reset is asserted so the bus stays idle
  // for the whole reset period, even though the FSM already sits in FETCH_REQ.
  assign imem_req_o    = (state_reg == FETCH_REQ) && !rsn_i;
  assign imem_addr_o   = fetch_addr;
  assign instr_o       = instr_reg;
  assign pc_o          = pc_reg;
  assign instr_valid_o = valid_reg;

  always_comb begin
    state_next     = state_reg;
    fetch_pc_next  = fetch_pc_reg;
    req_pc_next    = req_pc_reg;
    instr_next     = instr_reg;
    pc_next        = pc_reg;
    valid_next     = valid_reg;
    buf_instr_next = buf_instr_reg;
    buf_pc_next    = buf_pc_reg;
    load_new       = 1'b0;

    case (state_reg)
      FETCH_REQ: begin
        if (imem_gnt_i) begin
          req_pc_next   = fetch_addr;
          fetch_pc_next = fetch_addr + WORD_SIZE'(4);   // wraps modulo 2^WORD_SIZE
          state_next    = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (imem_rvalid_i) begin
          // Decode can only be blocked by a real instruction; a NOP slot
          // is always overwritable even if hazard_i happens to be high.
          if (!hazard_i || !valid_reg) begin
            instr_next = imem_rdata_i;
            pc_next    = req_pc_reg;
            valid_next = 1'b1;
            load_new   = 1'b1;
            state_next = FETCH_REQ;
          end else begin
            buf_instr_next = imem_rdata_i;
            buf_pc_next    = req_pc_reg;
            state_next     = HOLD;
          end
        end
      end
      HOLD: begin
        if (!hazard_i) begin
          instr_next = buf_instr_reg;
          pc_next    = buf_pc_reg;
          valid_next = 1'b1;
          load_new   = 1'b1;
          state_next = FETCH_REQ;
        end
      end
      FLUSH_WAIT: begin
        if (imem_rvalid_i) begin
          state_next = FETCH_REQ;
        end
      end
      default: state_next = FETCH_REQ;
    endcase

    // Redirect overrides everything above, including stalls and responses.
    if (tkbr_i) begin
      fetch_pc_next = new_pc_i & ALIGN_MASK;
      instr_next    = NOP_INSTR;
      valid_next    = 1'b0;
      load_new      = 1'b0;
      case (state_reg)
        FETCH_REQ:  state_next = imem_gnt_i    ? FLUSH_WAIT : FETCH_REQ;
        FETCH_WAIT: state_next = imem_rvalid_i ? FETCH_REQ  : FLUSH_WAIT;
        HOLD:       state_next = FETCH_REQ;
        // The old response may land in the same cycle as a second redirect.
        FLUSH_WAIT: state_next = imem_rvalid_i ? FETCH_REQ  : FLUSH_WAIT;
        default:    state_next = FETCH_REQ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      state_reg     <= FETCH_REQ;
      fetch_pc_reg  <= BOOT_ADDR;
      req_pc_reg    <= '0;
      instr_reg     <= NOP_INSTR;
      pc_reg        <= '0;
      valid_reg     <= 1'b0;
      buf_instr_reg <= NOP_INSTR;
      buf_pc_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      fetch_pc_reg  <= fetch_pc_next;
      req_pc_reg    <= req_pc_next;
      instr_reg     <= instr_next;
      pc_reg        <= pc_next;
      valid_reg     <= valid_next;
      buf_instr_reg <= buf_instr_next;
      buf_pc_reg    <= buf_pc_next;
    end
  end

`ifdef SEGRE_IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_reg;
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk_i) begin
    if (rsn_i) begin
      fetch_cnt_reg <= '0;
      stall_cnt_reg <= '0;
    end else begin
      if (load_new) begin
        fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      end
      if (hazard_i && valid_reg) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
    end
  end

  assign fetch_cnt_o = fetch_cnt_reg;
  assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_segre_if_stage.sv
// -----------------------------------------------------------------------------
// tb_segre_if_stage : directed bench for segre_if_stage.
// The stimulus process pushes each expected delivered (pc, instr) pair into a
// queue; a negedge monitor pops and compares whenever the DUT presents a new
// valid instruction. Other outputs are checked directly after clock edges.
// A small memory model can auto-grant and answer one cycle later with
// rdata = 0xA000_0000 | addr, or be driven by hand.
// -----------------------------------------------------------------------------
module tb_segre_if_stage;

  logic        clk_i = 1'b0;
  logic        rsn_i = 1'b1;
  logic        hazard_i = 1'b0;
  logic        tkbr_i = 1'b0;
  logic [31:0] new_pc_i = '0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_valid_o;
`ifdef SEGRE_IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_o;
  logic [31:0] stall_cnt_o;
`endif

  // memory model
  logic        auto_en = 1'b1;
  logic        man_gnt = 1'b0;
  logic        man_rvalid = 1'b0;
  logic [31:0] man_rdata = '0;
  logic        auto_rv = 1'b0;
  logic [31:0] auto_rd = '0;

  assign imem_gnt_i    = auto_en ? imem_req_o : man_gnt;
  assign imem_rvalid_i = auto_en ? auto_rv    : man_rvalid;
  assign imem_rdata_i  = auto_en ? auto_rd    : man_rdata;

  always @(posedge clk_i) begin
    auto_rv <= auto_en && imem_req_o && imem_gnt_i;
    auto_rd <= 32'hA000_0000 | imem_addr_o;
  end

  always #5 clk_i = ~clk_i;

  segre_if_stage dut (
    .clk_i         (clk_i),
    .rsn_i         (rsn_i),
    .hazard_i      (hazard_i),
    .tkbr_i        (tkbr_i),
    .new_pc_i      (new_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .instr_valid_o (instr_valid_o)
`ifdef SEGRE_IF_PERF_CNT_EN
    ,
    .fetch_cnt_o   (fetch_cnt_o),
    .stall_cnt_o   (stall_cnt_o)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] exp_pc_q[$];
  logic [31:0] exp_instr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic expect_delivery(input logic [31:0] pc, input logic [31:0] instr);
    exp_pc_q.push_back(pc);
    exp_instr_q.push_back(instr);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rsn_i = 1'b1;
    hazard_i = 1'b0;
    tkbr_i = 1'b0;
    man_gnt = 1'b0;
    man_rvalid = 1'b0;
    step();
    step();
  endtask

  // scoreboard monitor: a delivery is a valid instruction that differs from
  // what was shown on the previous cycle
  logic        prev_valid = 1'b0;
  logic [31:0] prev_pc = '0;
  logic [31:0] prev_instr = '0;

  always @(negedge clk_i) begin
    if (instr_valid_o && (!prev_valid || pc_o != prev_pc || instr_o != prev_instr)) begin
      vectors++;
      if (exp_pc_q.size() == 0) begin
        miscompares++;
        $display("FAIL delivery: unexpected pc 0x%08h instr 0x%08h", pc_o, instr_o);
      end else begin
        logic [31:0] ep;
        logic [31:0] ei;
        ep = exp_pc_q.pop_front();
        ei = exp_instr_q.pop_front();
        if (pc_o !== ep || instr_o !== ei) begin
          miscompares++;
          $display("FAIL delivery: got pc 0x%08h instr 0x%08h expected pc 0x%08h instr 0x%08h",
                   pc_o, instr_o, ep, ei);
        end else begin
          $display("ok   delivery: pc 0x%08h instr 0x%08h", pc_o, instr_o);
        end
      end
    end
    prev_valid = instr_valid_o;
    prev_pc    = pc_o;
    prev_instr = instr_o;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [31:0] t1_req [6] = '{1, 0, 1, 0, 1, 0};
  logic [31:0] t1_addr[6] = '{32'h0, 32'h0, 32'h4, 32'h0, 32'h8, 32'h0};

  initial begin
    // ---------------- 1: reset and zero-wait streaming ----------------
    auto_en = 1'b1;
    do_reset();
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_instr", instr_o, 32'h0000_0013);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
    expect_delivery(32'h0, 32'hA000_0000);
    expect_delivery(32'h4, 32'hA000_0004);
    expect_delivery(32'h8, 32'hA000_0008);
    rsn_i = 1'b0;
    #0;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t1_req%0d", k), {31'd0, imem_req_o}, t1_req[k]);
      if (t1_req[k] == 32'd1) chk($sformatf("t1_addr%0d", k), imem_addr_o, t1_addr[k]);
      step();
    end
    chk("t1_valid", {31'd0, instr_valid_o}, 32'd1);

    // ---------------- 2: hazard buffers a response ----------------
    do_reset();
    expect_delivery(32'h0, 32'hA000_0000);
    expect_delivery(32'h4, 32'hA000_0004);
    expect_delivery(32'h8, 32'hA000_0008);
    rsn_i = 1'b0;
    step();
    step();                               // pc0 delivered
    hazard_i = 1'b1;
    step();                               // request for 4 granted, waiting
    chk("t2_stall_instr0", instr_o, 32'hA000_0000);
    step();                               // response parked in buffer
    chk("t2_hold_req", {31'd0, imem_req_o}, 32'd0);
    chk("t2_hold_instr", instr_o, 32'hA000_0000);
    chk("t2_hold_pc", pc_o, 32'h0);
    step();
    chk("t2_hold_req2", {31'd0, imem_req_o}, 32'd0);
    hazard_i = 1'b0;
    step();                               // buffer released
    chk("t2_rel_instr", instr_o, 32'hA000_0004);
    chk("t2_rel_pc", pc_o, 32'h4);
    chk("t2_resume_addr", imem_addr_o, 32'h8);
    step();
    step();

    // ---------------- 3: redirect in FETCH_WAIT, late response ----------------
    auto_en = 1'b0;
    do_reset();
    rsn_i = 1'b0;
    man_gnt = 1'b1;
    step();                               // waiting
    man_gnt = 1'b0;
    tkbr_i = 1'b1;
    new_pc_i = 32'h100;
    step();                               // flushing
    tkbr_i = 1'b0;
    chk("t3_instr_nop", instr_o, 32'h0000_0013);
    chk("t3_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("t3_flush_req", {31'd0, imem_req_o}, 32'd0);
    step();
    chk("t3_flush_req2", {31'd0, imem_req_o}, 32'd0);
    man_rvalid = 1'b1;
    man_rdata = 32'hDEAD_BEEF;
    step();                               // stale data discarded
    man_rvalid = 1'b0;
    chk("t3_drop_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("t3_drop_instr", instr_o, 32'h0000_0013);
    chk("t3_new_req", {31'd0, imem_req_o}, 32'd1);
    chk("t3_new_addr", imem_addr_o, 32'h100);
    expect_delivery(32'h100, 32'h1111_1111);
    man_gnt = 1'b1;
    step();
    man_gnt = 1'b0;
    man_rvalid = 1'b1;
    man_rdata = 32'h1111_1111;
    step();
    man_rvalid = 1'b0;

    // ---------------- 4: redirect and rvalid together ----------------
    do_reset();
    rsn_i = 1'b0;
    man_gnt = 1'b1;
    step();
    man_gnt = 1'b0;
    man_rvalid = 1'b1;
    man_rdata = 32'h2222_2222;
    tkbr_i = 1'b1;
    new_pc_i = 32'h203;
    step();
    man_rvalid = 1'b0;
    tkbr_i = 1'b0;
    chk("t4_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("t4_instr", instr_o, 32'h0000_0013);
    chk("t4_addr", imem_addr_o, 32'h200);
    expect_delivery(32'h200, 32'h3333_3333);
    man_gnt = 1'b1;
    step();
    man_gnt = 1'b0;
    man_rvalid = 1'b1;
    man_rdata = 32'h3333_3333;
    step();
    man_rvalid = 1'b0;

    // ---------------- 5: reset during FETCH_WAIT ----------------
    do_reset();
    rsn_i = 1'b0;
    expect_delivery(32'h0, 32'h4444_4444);
    man_gnt = 1'b1;
    step();
    man_gnt = 1'b0;
    man_rvalid = 1'b1;
    man_rdata = 32'h4444_4444;
    step();
    man_rvalid = 1'b0;
    man_gnt = 1'b1;
    step();                               // request for 4 outstanding
    man_gnt = 1'b0;
    rsn_i = 1'b1;
    step();
    chk("t5_req", {31'd0, imem_req_o}, 32'd0);
    chk("t5_instr", instr_o, 32'h0000_0013);
    chk("t5_pc", pc_o, 32'h0);
    chk("t5_valid", {31'd0, instr_valid_o}, 32'd0);
    rsn_i = 1'b0;
    man_rvalid = 1'b1;                    // stray response for the old request
    man_rdata = 32'h5555_5555;
    #0;
    chk("t5_boot_req", {31'd0, imem_req_o}, 32'd1);
    chk("t5_boot_addr", imem_addr_o, 32'h0);
    step();
    man_rvalid = 1'b0;
    chk("t5_stray_valid", {31'd0, instr_valid_o}, 32'd0);
    chk("t5_stray_instr", instr_o, 32'h0000_0013);
    expect_delivery(32'h0, 32'h6666_6666);
    man_gnt = 1'b1;
    step();
    man_gnt = 1'b0;
    man_rvalid = 1'b1;
    man_rdata = 32'h6666_6666;
    step();
    man_rvalid = 1'b0;

    // ---------------- 6: PC wrap-around ----------------
    do_reset();
    rsn_i = 1'b0;
    tkbr_i = 1'b1;
    new_pc_i = 32'hFFFF_FFFC;
    step();                               // redirect while requesting, no grant
    tkbr_i = 1'b0;
    chk("t6_top_addr", imem_addr_o, 32'hFFFF_FFFC);
    chk("t6_top_req", {31'd0, imem_req_o}, 32'd1);
    expect_delivery(32'hFFFF_FFFC, 32'h7777_7777);
    expect_delivery(32'h0, 32'h8888_8888);
    man_gnt = 1'b1;
    step();
    man_gnt = 1'b0;
    man_rvalid = 1'b1;
    man_rdata = 32'h7777_7777;
    step();
    man_rvalid = 1'b0;
    chk("t6_wrap_addr", imem_addr_o, 32'h0);
    man_gnt = 1'b1;
    step();
    man_gnt = 1'b0;
    man_rvalid = 1'b1;
    man_rdata = 32'h8888_8888;
    step();
    man_rvalid = 1'b0;
`ifdef SEGRE_IF_PERF_CNT_EN
    chk("t6_fetch_cnt", fetch_cnt_o, 32'd2);
    chk("t6_stall_cnt", stall_cnt_o, 32'd0);
`endif

    step();
    step();
    chk("sb_empty", exp_pc_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
